// File: rtl/vscale_csr_unit.sv
// Machine-mode CSR file for the vscale RV32 core: CSR access, trap state, counters, HTIF port.
// Define CSR_TIMER_IRQ_EN to implement mtime/mtimecmp and the machine timer interrupt.
module vscale_csr_unit #(
    parameter int XPR_LEN        = 32,
    parameter int N_EXT_INTS     = 24,
    parameter int HTIF_PCR_WIDTH = 64,
    parameter int HART_ID        = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_EXT_INTS-1:0]     ext_interrupts,
    input  logic [11:0]               addr,
    input  logic [2:0]                cmd,
    input  logic [XPR_LEN-1:0]        wdata,
    output logic [1:0]                prv,
    output logic                      illegal_access,
    output logic [XPR_LEN-1:0]        rdata,
    input  logic                      retire,
    input  logic                      exception,
    input  logic [3:0]                exception_code,
    input  logic [XPR_LEN-1:0]        exception_load_addr,
    input  logic [XPR_LEN-1:0]        exception_PC,
    output logic [XPR_LEN-1:0]        epc,
    input  logic                      eret,
    output logic [XPR_LEN-1:0]        handler_PC,
    output logic                      interrupt_pending,
    input  logic                      interrupt_taken,
    input  logic                      htif_reset,
    input  logic                      htif_pcr_req_valid,
    output logic                      htif_pcr_req_ready,
    input  logic                      htif_pcr_req_rw,
    input  logic [11:0]               htif_pcr_req_addr,
    input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    output logic                      htif_pcr_resp_valid,
    input  logic                      htif_pcr_resp_ready,
    output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);

`ifdef CSR_TIMER_IRQ_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd5;
    localparam logic [2:0] CMD_SET   = 3'd6;
    localparam logic [2:0] CMD_CLEAR = 3'd7;

    logic                      ie_q, ie_d, ie1_q, ie1_d;
    logic                      mie7_q, mie7_d, mie11_q, mie11_d;
    logic                      mtip_q, mtip_d;
    logic [XPR_LEN-1:0]        mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XPR_LEN-1:0]        mbadaddr_q, mbadaddr_d, mscratch_q, mscratch_d;
    logic [XPR_LEN-1:0]        mtimecmp_q, mtimecmp_d, mtime_q, mtime_d;
    logic [XPR_LEN-1:0]        mtohost_q, mtohost_d, mfromhost_q, mfromhost_d;
    logic [63:0]               cycle_q, cycle_d, instret_q, instret_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [HTIF_PCR_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [XPR_LEN-1:0] mstatus_val, mie_val, mip_val, wr_val;
    logic [XPR_LEN:0]   core_rd, host_rd;
    logic               meip, wr_type, wen, host_accept, timer_irq;
    logic               unused_bits;

    assign meip        = |ext_interrupts;
    assign mstatus_val = {{(XPR_LEN-6){1'b0}}, 2'b11, ie1_q, 2'b11, ie_q};
    assign mie_val     = {{(XPR_LEN-12){1'b0}}, mie11_q, 3'b0, mie7_q, 7'b0};
    assign mip_val     = {{(XPR_LEN-12){1'b0}}, meip, 3'b0, mtip_q, 7'b0};
    assign timer_irq   = mie7_q & mtip_q;

    // Returns {mapped, value}; unmapped addresses read as zero.
    function automatic logic [XPR_LEN:0] csr_read(input logic [11:0] a);
        logic [XPR_LEN:0] r;
        r = '0;
        case (a)
            12'h300: r = {1'b1, mstatus_val};
            12'h301: r = {1'b1, 32'h0000_0100};
            12'h304: r = {1'b1, mie_val};
            12'h321: r = {TIMER_EN, mtimecmp_q};
            12'h340: r = {1'b1, mscratch_q};
            12'h341: r = {1'b1, mepc_q[XPR_LEN-1:2], 2'b00};
            12'h342: r = {1'b1, mcause_q};
            12'h343: r = {1'b1, mbadaddr_q};
            12'h344: r = {1'b1, mip_val};
            12'h701: r = {TIMER_EN, mtime_q};
            12'h780: r = {1'b1, mtohost_q};
            12'h781: r = {1'b1, mfromhost_q};
            12'hC00, 12'hC01: r = {1'b1, cycle_q[31:0]};
            12'hC02: r = {1'b1, instret_q[31:0]};
            12'hC80, 12'hC81: r = {1'b1, cycle_q[63:32]};
            12'hC82: r = {1'b1, instret_q[63:32]};
            12'hF00: r = {1'b1, 32'h0000_0100};
            12'hF01: r = {1'b1, 32'h0000_8000};
            12'hF10: r = {1'b1, 32'(HART_ID)};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        core_rd        = csr_read(addr);
        host_rd        = csr_read(htif_pcr_req_addr);
        wr_type        = cmd[2] & (cmd[1] | cmd[0]);
        illegal_access = (cmd != CMD_IDLE) &
                         (!core_rd[XPR_LEN] | (wr_type & (addr[11:10] == 2'b11)));
        wen            = wr_type & !illegal_access;
        rdata          = core_rd[XPR_LEN-1:0];
        case (cmd)
            CMD_SET:   wr_val = rdata | wdata;
            CMD_CLEAR: wr_val = rdata & ~wdata;
            default:   wr_val = wdata;
        endcase
        host_accept    = htif_pcr_req_valid & !resp_valid_q;
    end

    // Later assignments take priority: increments, then core writes, then traps, then host.
    always_comb begin
        ie_d         = ie_q;
        ie1_d        = ie1_q;
        mie7_d       = mie7_q;
        mie11_d      = mie11_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mbadaddr_d   = mbadaddr_q;
        mscratch_d   = mscratch_q;
        mtimecmp_d   = mtimecmp_q;
        mtohost_d    = mtohost_q;
        mfromhost_d  = mfromhost_q;
        cycle_d      = cycle_q + 64'd1;
        instret_d    = instret_q + {63'b0, retire};
        mtime_d      = TIMER_EN ? mtime_q + 32'd1 : mtime_q;
        mtip_d       = TIMER_EN & (mtip_q | (mtime_q == mtimecmp_q));
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        if (wen) begin
            case (addr)
                12'h300: begin
                    ie_d  = wr_val[0];
                    ie1_d = wr_val[3];
                end
                12'h304: begin
                    mie7_d  = TIMER_EN & wr_val[7];
                    mie11_d = wr_val[11];
                end
                12'h321: begin
                    mtimecmp_d = wr_val;
                    mtip_d     = 1'b0;
                end
                12'h340: mscratch_d  = wr_val;
                12'h341: mepc_d      = wr_val;
                12'h342: mcause_d    = wr_val;
                12'h343: mbadaddr_d  = wr_val;
                12'h701: mtime_d     = wr_val;
                12'h780: mtohost_d   = wr_val;
                12'h781: mfromhost_d = wr_val;
                default: ;
            endcase
        end

        if (exception | interrupt_taken) begin
            ie1_d  = ie_q;
            ie_d   = 1'b0;
            mepc_d = exception_PC;
            if (exception) begin
                mcause_d = {{(XPR_LEN-4){1'b0}}, exception_code};
                if (exception_code[3:2] == 2'b01)
                    mbadaddr_d = exception_load_addr;
            end else begin
                mcause_d = {1'b1, {(XPR_LEN-5){1'b0}}, timer_irq ? 4'd7 : 4'd11};
            end
        end else if (eret) begin
            ie_d  = ie1_q;
            ie1_d = 1'b1;
        end

        if (host_accept) begin
            resp_valid_d = 1'b1;
            resp_data_d  = {{(HTIF_PCR_WIDTH-XPR_LEN){1'b0}}, host_rd[XPR_LEN-1:0]};
            if (htif_pcr_req_rw && htif_pcr_req_addr == 12'h780)
                mtohost_d = htif_pcr_req_data[XPR_LEN-1:0];
            if (htif_pcr_req_rw && htif_pcr_req_addr == 12'h781)
                mfromhost_d = htif_pcr_req_data[XPR_LEN-1:0];
        end else if (resp_valid_q && htif_pcr_resp_ready) begin
            resp_valid_d = 1'b0;
        end

        if (htif_reset) begin
            mtohost_d   = '0;
            mfromhost_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q         <= 1'b0;
            ie1_q        <= 1'b0;
            mie7_q       <= 1'b0;
            mie11_q      <= 1'b0;
            mtip_q       <= 1'b0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mbadaddr_q   <= '0;
            mscratch_q   <= '0;
            mtimecmp_q   <= '0;
            mtime_q      <= '0;
            mtohost_q    <= '0;
            mfromhost_q  <= '0;
            cycle_q      <= '0;
            instret_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            ie_q         <= ie_d;
            ie1_q        <= ie1_d;
            mie7_q       <= mie7_d;
            mie11_q      <= mie11_d;
            mtip_q       <= mtip_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mbadaddr_q   <= mbadaddr_d;
            mscratch_q   <= mscratch_d;
            mtimecmp_q   <= mtimecmp_d;
            mtime_q      <= mtime_d;
            mtohost_q    <= mtohost_d;
            mfromhost_q  <= mfromhost_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign prv                 = 2'b11;
    assign epc                 = {mepc_q[XPR_LEN-1:2], 2'b00};
    assign handler_PC          = 32'h0000_0100;
    assign interrupt_pending   = ie_q & (timer_irq | (mie11_q & meip));
    assign htif_pcr_req_ready  = !resp_valid_q;
    assign htif_pcr_resp_valid = resp_valid_q;
    assign htif_pcr_resp_data  = resp_data_q;
    assign unused_bits = ^{htif_pcr_req_data[HTIF_PCR_WIDTH-1:XPR_LEN], host_rd[XPR_LEN],
                           mepc_q[1:0]};

endmodule

// File: tb/tb_vscale_csr_unit.sv
// Directed scoreboard bench for vscale_csr_unit; timer checks follow CSR_TIMER_IRQ_EN.
module tb_vscale_csr_unit;

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd4;
    localparam logic [2:0] CMD_WRITE = 3'd5;
    localparam logic [2:0] CMD_SET   = 3'd6;
    localparam logic [2:0] CMD_CLEAR = 3'd7;

    localparam int K_RDATA = 0, K_ILL = 1, K_PEND = 2, K_EPC = 3, K_RESPV = 4;
    localparam int K_REQR = 5, K_RESPD = 6, K_PRV = 7, K_HPC = 8;

`ifdef CSR_TIMER_IRQ_EN
    localparam logic [31:0] MTIP_AT_START = 32'h80;
`else
    localparam logic [31:0] MTIP_AT_START = 32'h0;
`endif

    logic        clk, reset;
    logic [23:0] ext_interrupts;
    logic [11:0] addr;
    logic [2:0]  cmd;
    logic [31:0] wdata;
    logic [1:0]  prv;
    logic        illegal_access;
    logic [31:0] rdata;
    logic        retire, exception;
    logic [3:0]  exception_code;
    logic [31:0] exception_load_addr, exception_PC, epc;
    logic        eret;
    logic [31:0] handler_PC;
    logic        interrupt_pending, interrupt_taken, htif_reset;
    logic        htif_pcr_req_valid, htif_pcr_req_ready, htif_pcr_req_rw;
    logic [11:0] htif_pcr_req_addr;
    logic [63:0] htif_pcr_req_data;
    logic        htif_pcr_resp_valid, htif_pcr_resp_ready;
    logic [63:0] htif_pcr_resp_data;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] tb_cycle, tb_instret;

    vscale_csr_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .ext_interrupts      (ext_interrupts),
        .addr                (addr),
        .cmd                 (cmd),
        .wdata               (wdata),
        .prv                 (prv),
        .illegal_access      (illegal_access),
        .rdata               (rdata),
        .retire              (retire),
        .exception           (exception),
        .exception_code      (exception_code),
        .exception_load_addr (exception_load_addr),
        .exception_PC        (exception_PC),
        .epc                 (epc),
        .eret                (eret),
        .handler_PC          (handler_PC),
        .interrupt_pending   (interrupt_pending),
        .interrupt_taken     (interrupt_taken),
        .htif_reset          (htif_reset),
        .htif_pcr_req_valid  (htif_pcr_req_valid),
        .htif_pcr_req_ready  (htif_pcr_req_ready),
        .htif_pcr_req_rw     (htif_pcr_req_rw),
        .htif_pcr_req_addr   (htif_pcr_req_addr),
        .htif_pcr_req_data   (htif_pcr_req_data),
        .htif_pcr_resp_valid (htif_pcr_resp_valid),
        .htif_pcr_resp_ready (htif_pcr_resp_ready),
        .htif_pcr_resp_data  (htif_pcr_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference counters: cycles and retirements since reset was released.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_cycle   <= '0;
            tb_instret <= '0;
        end else begin
            tb_cycle   <= tb_cycle + 64'd1;
            tb_instret <= tb_instret + {63'b0, retire};
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_RDATA: return {32'b0, rdata};
            K_ILL:   return {63'b0, illegal_access};
            K_PEND:  return {63'b0, interrupt_pending};
            K_EPC:   return {32'b0, epc};
            K_RESPV: return {63'b0, htif_pcr_resp_valid};
            K_REQR:  return {63'b0, htif_pcr_req_ready};
            K_RESPD: return htif_pcr_resp_data;
            K_PRV:   return {62'b0, prv};
            default: return {32'b0, handler_PC};
        endcase
    endfunction

    task automatic push_exp(input string tag, input int kind, input logic [63:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Drive a new step at the falling edge; one-shot strobes are cleared every step.
    task automatic applyStimulus(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd                = c;
        addr               = a;
        wdata              = d;
        exception          = 1'b0;
        eret               = 1'b0;
        interrupt_taken    = 1'b0;
        htif_pcr_req_valid = 1'b0;
        htif_reset         = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [63:0] obs;
        #2;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            total++;
            assert (obs === e.exp)
            else begin
                bad++;
                $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic read_check(input logic [11:0] a, input logic [31:0] v, input string tag);
        applyStimulus(CMD_READ, a, 32'h0);
        push_exp(tag, K_RDATA, {32'b0, v});
        push_exp({tag, "_ill"}, K_ILL, 64'd0);
        checkOutput();
    endtask

    task automatic host_req(input logic rw, input logic [11:0] a, input logic [63:0] d);
        htif_pcr_req_valid = 1'b1;
        htif_pcr_req_rw    = rw;
        htif_pcr_req_addr  = a;
        htif_pcr_req_data  = d;
    endtask

    initial begin
        reset = 1'b1; ext_interrupts = '0; addr = '0; cmd = CMD_IDLE; wdata = '0;
        retire = 1'b0; exception = 1'b0; exception_code = '0; exception_load_addr = '0;
        exception_PC = '0; eret = 1'b0; interrupt_taken = 1'b0; htif_reset = 1'b0;
        htif_pcr_req_valid = 1'b0; htif_pcr_req_rw = 1'b0; htif_pcr_req_addr = '0;
        htif_pcr_req_data = '0; htif_pcr_resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Build up some state, including a held host response, then reset mid-run.
        applyStimulus(CMD_WRITE, 12'h340, 32'h1234);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        host_req(1'b0, 12'h340, 64'h0);
        htif_pcr_resp_ready = 1'b0;
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        push_exp("pre_rst_respv", K_RESPV, 64'd1);
        push_exp("pre_rst_respd", K_RESPD, 64'h1234);
        checkOutput();
        #1 reset = 1'b1;
        push_exp("rst_respv", K_RESPV, 64'd0);
        checkOutput();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        htif_pcr_resp_ready = 1'b1;

        applyStimulus(CMD_READ, 12'h300, 32'h0);
        push_exp("rst_mstatus", K_RDATA, 64'h36);
        push_exp("rst_ill", K_ILL, 64'd0);
        push_exp("rst_reqr", K_REQR, 64'd1);
        push_exp("rst_pend", K_PEND, 64'd0);
        push_exp("rst_epc", K_EPC, 64'd0);
        push_exp("prv", K_PRV, 64'd3);
        push_exp("handler_pc", K_HPC, 64'h100);
        checkOutput();
        read_check(12'hF00, 32'h100, "mcpuid");
        read_check(12'h340, 32'h0, "rst_mscratch");

        applyStimulus(CMD_WRITE, 12'h340, 32'hA5A5_A5A5);
        push_exp("wr_ill", K_ILL, 64'd0);
        checkOutput();
        read_check(12'h340, 32'hA5A5_A5A5, "scr_write");
        applyStimulus(CMD_SET, 12'h340, 32'h0F);
        checkOutput();
        read_check(12'h340, 32'hA5A5_A5AF, "scr_set");
        applyStimulus(CMD_CLEAR, 12'h340, 32'hA0);
        checkOutput();
        read_check(12'h340, 32'hA5A5_A50F, "scr_clear");

        // Illegal accesses: read-only counter space and unmapped addresses.
        applyStimulus(CMD_WRITE, 12'hC00, 32'h5);
        push_exp("wr_c00_ill", K_ILL, 64'd1);
        checkOutput();
        applyStimulus(CMD_READ, 12'hC00, 32'h0);
        push_exp("cycle_lo", K_RDATA, {32'b0, tb_cycle[31:0]});
        checkOutput();
        read_check(12'hC80, 32'h0, "cycle_hi");
        applyStimulus(CMD_WRITE, 12'h123, 32'hFFFF_FFFF);
        push_exp("wr_123_ill", K_ILL, 64'd1);
        checkOutput();
        applyStimulus(CMD_READ, 12'h123, 32'h0);
        push_exp("rd_123_ill", K_ILL, 64'd1);
        push_exp("rd_123_data", K_RDATA, 64'd0);
        checkOutput();
        applyStimulus(CMD_SET, 12'hF10, 32'h1);
        push_exp("set_f10_ill", K_ILL, 64'd1);
        checkOutput();
        read_check(12'hF10, 32'h0, "mhartid");

        for (int i = 0; i < 3; i++) begin
            applyStimulus(CMD_IDLE, 12'h0, 32'h0);
            retire = 1'b1;
            checkOutput();
        end
        applyStimulus(CMD_READ, 12'hC02, 32'h0);
        retire = 1'b0;
        push_exp("instret", K_RDATA, {32'b0, tb_instret[31:0]});
        checkOutput();

        // Exception entry, return, and exception overriding a same-cycle mcause write.
        applyStimulus(CMD_WRITE, 12'h300, 32'h1);
        checkOutput();
        read_check(12'h300, 32'h37, "mstatus_ie");
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        exception = 1'b1; exception_code = 4'd5;
        exception_PC = 32'h240; exception_load_addr = 32'h1003;
        checkOutput();
        applyStimulus(CMD_READ, 12'h341, 32'h0);
        push_exp("mepc", K_RDATA, 64'h240);
        push_exp("epc_port", K_EPC, 64'h240);
        checkOutput();
        read_check(12'h342, 32'h5, "mcause_exc");
        read_check(12'h343, 32'h1003, "mbadaddr");
        read_check(12'h300, 32'h3E, "mstatus_trap");
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        eret = 1'b1;
        checkOutput();
        read_check(12'h300, 32'h3F, "mstatus_eret");
        applyStimulus(CMD_WRITE, 12'h342, 32'h9);
        exception = 1'b1; exception_code = 4'd2;
        exception_PC = 32'h302; exception_load_addr = 32'h5555;
        eret = 1'b1;
        checkOutput();
        read_check(12'h342, 32'h2, "mcause_override");
        read_check(12'h343, 32'h1003, "mbadaddr_kept");
        read_check(12'h341, 32'h300, "mepc_align");
        read_check(12'h300, 32'h3E, "mstatus_exc_eret");

        // External interrupt.
        applyStimulus(CMD_WRITE, 12'h304, 32'h880);
        checkOutput();
        read_check(12'h304, 32'h800 | (MTIP_AT_START != 0 ? 32'h80 : 32'h0), "mie_mask");
        applyStimulus(CMD_WRITE, 12'h304, 32'h800);
        checkOutput();
        applyStimulus(CMD_SET, 12'h300, 32'h1);
        ext_interrupts = 24'h000100;
        push_exp("pend_ie0", K_PEND, 64'd0);
        checkOutput();
        applyStimulus(CMD_READ, 12'h344, 32'h0);
        push_exp("mip_ext", K_RDATA, {32'b0, 32'h800 | MTIP_AT_START});
        push_exp("pend_ext", K_PEND, 64'd1);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        interrupt_taken = 1'b1;
        checkOutput();
        applyStimulus(CMD_READ, 12'h342, 32'h0);
        ext_interrupts = '0;
        push_exp("mcause_ext", K_RDATA, 64'h8000_000B);
        push_exp("pend_taken", K_PEND, 64'd0);
        checkOutput();

`ifdef CSR_TIMER_IRQ_EN
        applyStimulus(CMD_WRITE, 12'h304, 32'h80);
        checkOutput();
        applyStimulus(CMD_SET, 12'h300, 32'h1);
        checkOutput();
        applyStimulus(CMD_WRITE, 12'h321, 32'h0);
        wdata = tb_cycle[31:0] + 32'd10;
        checkOutput();
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(CMD_IDLE, 12'h0, 32'h0);
            push_exp($sformatf("timer_pend_c%0d", k), K_PEND, (k == 11) ? 64'd1 : 64'd0);
            checkOutput();
        end
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        interrupt_taken = 1'b1;
        checkOutput();
        applyStimulus(CMD_READ, 12'h342, 32'h0);
        push_exp("mcause_timer", K_RDATA, 64'h8000_0007);
        push_exp("pend_timer_taken", K_PEND, 64'd0);
        checkOutput();
        applyStimulus(CMD_WRITE, 12'h321, 32'hFFFF_FFFF);
        checkOutput();
        read_check(12'h344, 32'h0, "mtip_cleared");
`else
        applyStimulus(CMD_READ, 12'h321, 32'h0);
        push_exp("mtimecmp_ill", K_ILL, 64'd1);
        push_exp("mtimecmp_rd", K_RDATA, 64'd0);
        checkOutput();
        applyStimulus(CMD_WRITE, 12'h701, 32'h7);
        push_exp("mtime_ill", K_ILL, 64'd1);
        checkOutput();
`endif

        // HTIF write, read, and response back-pressure.
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        host_req(1'b1, 12'h780, 64'hDEAD_0000_0000_0001);
        push_exp("htif_reqr_idle", K_REQR, 64'd1);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        push_exp("htif_wr_respv", K_RESPV, 64'd1);
        push_exp("htif_wr_respd", K_RESPD, 64'd0);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        push_exp("htif_resp_clr", K_RESPV, 64'd0);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        host_req(1'b0, 12'h780, 64'h0);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        htif_pcr_resp_ready = 1'b0;
        push_exp("htif_rd_respd", K_RESPD, 64'h1);
        push_exp("htif_rd_respv", K_RESPV, 64'd1);
        push_exp("htif_busy_reqr", K_REQR, 64'd0);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        push_exp("htif_hold_respv", K_RESPV, 64'd1);
        push_exp("htif_hold_reqr", K_REQR, 64'd0);
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        htif_pcr_resp_ready = 1'b1;
        checkOutput();
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        push_exp("htif_release", K_RESPV, 64'd0);
        checkOutput();
        read_check(12'h780, 32'h1, "core_tohost");

        applyStimulus(CMD_WRITE, 12'h781, 32'h55);
        host_req(1'b1, 12'h781, 64'h77);
        checkOutput();
        read_check(12'h781, 32'h77, "host_wins");
        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        htif_reset = 1'b1;
        checkOutput();
        read_check(12'h780, 32'h0, "htif_rst_tohost");
        read_check(12'h781, 32'h0, "htif_rst_fromhost");

        applyStimulus(CMD_IDLE, 12'h0, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
